shr_share_arb: RTL and testbench
================================

// Module: shr_share_arb
// PURPOSE
//  Shares one combinational 32-bit right-shifter (6-bit shift count, 0..32) between two requesters.
//  Arbitrates round-robin and drives the shared shifter's n/in inputs.
//  Registers the shifter result and returns it on a per-requester valid/ready response channel.
//  Sits between ALU issue logic (requester 0), address/extract logic (requester 1) and the shifter.
// PARAMETERS
//  DATA_W  32  data width; must match the shifter (only 32 is supported)
//  CNT_W   6   shift-count width; encodes 0..32, where 32 = all bits removed
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   2       per-requester request valid; bit i = requester i
//  req_ready   out  2       per-requester request accepted this cycle
//  req_n0      in   6       requester 0 shift count
//  req_in0     in   32      requester 0 operand
//  req_n1      in   6       requester 1 shift count
//  req_in1     in   32      requester 1 operand
//  sh_n        out  6       to shared shifter: count of the granted request
//  sh_in       out  32      to shared shifter: operand of the granted request
//  sh_out      in   32      from shared shifter: combinational result
//  rsp_valid   out  2       result valid for requester i (at most one bit set)
//  rsp_ready   in   2       requester i consumes its result
//  rsp_data    out  32      held shift result
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_data=0, req_ready=0, held id=0, last_grant=1 (requester 0 wins first).
//    Reset is asynchronous. A held result is discarded without handshake.
//  Response slot: a single register {full, id, data}. rsp_valid[i] = full && (id==i).
//    rsp_fire = full && rsp_ready[id].
//  Slot free: free = !full || rsp_fire. Accept and drain may occur in the same cycle,
//    giving one result per cycle at full throughput.
//  Arbitration (combinational, evaluated every cycle):
//    - Only requester i valid -> grant i.
//    - Both valid -> grant !last_grant.
//    - No request -> no grant.
//  Request handshake:
//    - req_ready[g] = free && grant==g; the other bit is 0.
//    - req_ready never depends on rsp_ready of the other requester's slot.
//  Shifter drive:
//    - sh_n/sh_in = operands of the grant.
//    - When there is no grant, drive requester 0's operands; the value is don't-care, but there is no X.
//  Accept (req_valid[g] && req_ready[g]) at edge t:
//    - full<=1, id<=g, data<=sh_out, last_grant<=g.
//    - rsp_valid is visible from cycle t+1, so latency is 1 cycle.
//  rsp_fire without accept: full<=0. data holds its last value.
//  While full and not ready, rsp_data/id are stable. Requesters must hold req_* stable until accepted.
//  Count >32 (n[5]=1 with low bits nonzero) is passed through unchanged.
//    The shifter yields 0, identical to n=32. No error is flagged.
//  Fairness: with both requesters continuously valid and rsp_ready held at 1, grants alternate 0,1,0,1.
//  Holding the wrong rsp_ready (bit != id) has no effect; the result stays held.
// TESTING
//  T1 reset:
//    - Assert rst_n=0 mid-transfer with full=1.
//    - Expect rsp_valid=0 and rsp_data=0 immediately, without a clock edge.
//    - After release, both requesters valid -> requester 0 is granted first.
//  T2 single path:
//    - req_valid=01, n0=4, in0=0xF000_0000, rsp_ready=01.
//    - Expect req_ready=01 at t.
//    - Expect rsp_valid=01 and rsp_data=0x0F00_0000 at t+1.
//  T3 boundary counts:
//    - n=0, in=0xDEAD_BEEF -> 0xDEAD_BEEF.
//    - n=31, in=0x8000_0000 -> 0x1.
//    - n=32 -> 0; n=63 -> 0.
//  T4 round-robin:
//    - Both valid for 6 cycles, rsp_ready=11.
//    - Expect grants 0,1,0,1,0,1.
//    - Expect one result per cycle with the correct id per operand.
//  T5 backpressure:
//    - Result for requester 1 held with rsp_ready=00 for 5 cycles, requester 0 valid.
//    - Expect req_ready=00, and rsp_data/id stable.
//    - When rsp_ready=10, expect drain and accept of requester 0 in the same cycle.
//  T6 wrong-ready:
//    - full, id=0, rsp_ready=10.
//    - Expect no drain and rsp_valid=01 unchanged.

Source files
------------

// File: rtl/shr_share_arb.sv
// shr_share_arb: round-robin arbiter that shares one combinational 32-bit
// right-shifter between two requesters. The shifter result is captured in a
// single response slot {full, id, data}. The slot is returned to its owner
// over a per-requester valid/ready channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1 for the same requester. The sender
// holds its payload stable while valid is high and not yet accepted. Ready
// may depend combinationally on valid. valid never depends on ready.
module shr_share_arb #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CNT_W-1:0]  req_n0,
  input  logic [DATA_W-1:0] req_in0,
  input  logic [CNT_W-1:0]  req_n1,
  input  logic [DATA_W-1:0] req_in1,
  output logic [CNT_W-1:0]  sh_n,
  output logic [DATA_W-1:0] sh_in,
  input  logic [DATA_W-1:0] sh_out,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data
);

  // Response slot and arbitration history.
  logic              full_q, full_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_grant_q, last_grant_d;

  // Combinational arbitration results.
  logic grant_valid;
  logic grant_id;
  logic rsp_fire;
  logic slot_free;
  logic accept;

  // Round-robin grant: a lone requester wins outright. On a tie the
  // requester that did not win last time wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
      end
    endcase
  end

  // Slot occupancy.
  // The slot is free when it is empty or is being drained this cycle.
  // This allows one accept per cycle at full throughput.
  always_comb begin
    rsp_fire  = full_q && rsp_ready[id_q];
    slot_free = !full_q || rsp_fire;
    accept    = grant_valid && slot_free;
  end

  // Request ready goes only to the granted requester, and only when the slot can take the result.
  always_comb begin
    req_ready = 2'b00;
    if (grant_valid && slot_free) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Drive the shared shifter from the granted requester.
  // With no grant, grant_id is 0, so requester 0's operands appear. This keeps the shifter inputs free of X.
  always_comb begin
    sh_n  = grant_id ? req_n1  : req_n0;
    sh_in = grant_id ? req_in1 : req_in0;
  end

  // Response outputs come straight from the slot.
  always_comb begin
    rsp_valid = 2'b00;
    if (full_q) begin
      rsp_valid[id_q] = 1'b1;
    end
    rsp_data = data_q;
  end

  // Next-state for the slot and the round-robin pointer.
  // An accept overrides a drain in the same cycle.
  // data is kept after a drain.
  always_comb begin
    full_d       = full_q;
    id_d         = id_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      full_d       = 1'b1;
      id_d         = grant_id;
      data_d       = sh_out;
      last_grant_d = grant_id;
    end else if (rsp_fire) begin
      full_d = 1'b0;
    end
  end

  // State registers.
  // last_grant resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= 1'b0;
      id_q         <= 1'b0;
      data_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      full_q       <= full_d;
      id_q         <= id_d;
      data_q       <= data_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_shr_share_arb.sv
// tb_shr_share_arb: directed bench for the shared-shifter arbiter. The external
// shifter is modelled behaviourally. Results are tracked as {id, data} entries.
module tb_shr_share_arb;

  localparam int W = 33;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_n0;
  logic [31:0] req_in0;
  logic [5:0]  req_n1;
  logic [31:0] req_in1;
  logic [5:0]  sh_n;
  logic [31:0] sh_in;
  logic [31:0] sh_out;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;

  logic [W-1:0] exp_q[$];
  logic         grant_log[$];
  int           checks;
  int           failures;

  shr_share_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n0    (req_n0),
    .req_in0   (req_in0),
    .req_n1    (req_n1),
    .req_in1   (req_in1),
    .sh_n      (sh_n),
    .sh_in     (sh_in),
    .sh_out    (sh_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // External combinational shifter: a count of 32 or more clears every bit.
  assign sh_out = sh_n[5] ? 32'h0 : (sh_in >> sh_n[4:0]);

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_shift(input logic [5:0] n, input logic [31:0] v);
    if (n >= 6'd32) return 32'h0;
    return v >> n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitors one cycle, then advances to the next falling edge.
  // It compares any draining result against the scoreboard.
  // It pushes the expected result for any accept.
  task automatic tick();
    logic [1:0]   fire;
    logic [1:0]   acc;
    logic [W-1:0] e;
    #1;
    fire = rsp_valid & rsp_ready;
    if (fire != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id_data", {31'd0, fire[1], rsp_data}, {31'd0, e});
      end
    end
    acc = req_valid & req_ready;
    if (acc != 2'b00) begin
      if (acc[1]) exp_q.push_back({1'b1, model_shift(req_n1, req_in1)});
      else        exp_q.push_back({1'b0, model_shift(req_n0, req_in0)});
      grant_log.push_back(acc[1]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver task: drives the request inputs of one requester.
  task automatic drive_req(input int r, input logic [5:0] n, input logic [31:0] v);
    if (r == 0) begin
      req_n0 = n; req_in0 = v;
    end else begin
      req_n1 = n; req_in1 = v;
    end
  endtask

  logic [5:0]  t3_n   [4];
  logic [31:0] t3_in  [4];
  logic [31:0] t3_exp [4];
  logic        g;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_n0 = '0; req_in0 = '0; req_n1 = '0; req_in1 = '0;
    t3_n[0] = 6'd0;  t3_in[0] = 32'hDEAD_BEEF; t3_exp[0] = 32'hDEAD_BEEF;
    t3_n[1] = 6'd31; t3_in[1] = 32'h8000_0000; t3_exp[1] = 32'h0000_0001;
    t3_n[2] = 6'd32; t3_in[2] = 32'hFFFF_FFFF; t3_exp[2] = 32'h0;
    t3_n[3] = 6'd63; t3_in[3] = 32'hFFFF_FFFF; t3_exp[3] = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: first tie goes to requester 0, then async reset with a held result.
    req_valid = 2'b11; rsp_ready = 2'b00;
    drive_req(0, 6'd1, 32'h100);
    drive_req(1, 6'd2, 32'h100);
    #1 chk("t1_first_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    #1 chk("t1_held_valid", 64'(rsp_valid), 64'd1);
    chk("t1_held_data", 64'(rsp_data), 64'h80);
    rst_n = 1'b0;
    #1 chk("t1_async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t1_async_rsp_data", 64'(rsp_data), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1 chk("t1_post_reset_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b10;
    #1 chk("t1_second_grant", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    tick();

    // T2: single path, latency one cycle.
    req_valid = 2'b01; rsp_ready = 2'b01;
    drive_req(0, 6'd4, 32'hF000_0000);
    #1 chk("t2_req_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    #1 chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_data", 64'(rsp_data), 64'h0F00_0000);
    tick();

    // T3: boundary shift counts, alternating requesters.
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      drive_req(k % 2, t3_n[k], t3_in[k]);
      req_valid = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      req_valid = 2'b00;
      #1 chk("t3_boundary_data", 64'(rsp_data), 64'(t3_exp[k]));
      tick();
    end

    // T4: round-robin with both requesters continuously valid.
    grant_log.delete();
    drive_req(0, 6'($urandom_range(0, 40)), $urandom);
    drive_req(1, 6'($urandom_range(0, 40)), $urandom);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        #1 chk("t4_result_per_cycle", 64'(rsp_valid != 2'b00), 64'd1);
      end
      tick();
      if (grant_log.size() > 0) begin
        g = grant_log[grant_log.size() - 1];
        drive_req(g ? 1 : 0, 6'($urandom_range(0, 40)), $urandom);
      end
    end
    req_valid = 2'b00;
    tick();
    chk("t4_grant_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      chk("t4_grant_order", 64'(grant_log[i]), 64'(i % 2));
    end

    // T5: backpressure on a requester-1 result while requester 0 waits.
    drive_req(1, 6'd8, 32'hAABB_CCDD);
    req_valid = 2'b10; rsp_ready = 2'b00;
    tick();
    drive_req(0, 6'd4, 32'h1234_5678);
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t5_req_ready_blocked", 64'(req_ready), 64'd0);
      chk("t5_rsp_valid_stable", 64'(rsp_valid), 64'd2);
      chk("t5_rsp_data_stable", 64'(rsp_data), 64'h00AA_BBCC);
      tick();
    end
    rsp_ready = 2'b10;
    #1 chk("t5_drain_and_accept", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;

    // T6: the wrong-ready bit leaves the held result alone.
    for (int i = 0; i < 3; i++) begin
      #1 chk("t6_rsp_valid_held", 64'(rsp_valid), 64'd1);
      chk("t6_rsp_data_held", 64'(rsp_data), 64'h0123_4567);
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    #1 chk("t6_drained", 64'(rsp_valid), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
